// File: rtl/vga_cons_pkg.sv
// vga_cons_pkg: shared register map, drain FSM states and status bit positions for the text console controller
package vga_cons_pkg;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [6:0] BLANK_CHAR_DEF = 7'h20;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_CLEARING = 2;
  localparam int ST_IRQ_EN = 3;
  localparam int ST_LEVEL_LSB = 8;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_SETTLE, S_WAIT, S_CLEAR} state_t;
endpackage

// File: rtl/vga_cons_fifo.sv
// vga_cons_fifo: synchronous character FIFO with flush and fill-level output
module vga_cons_fifo
  import vga_cons_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 7,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign dout = mem[rd_ptr];
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  always_ff @(posedge HCLK)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
endmodule

// File: rtl/vga_text_console_ctrl.sv
// vga_text_console_ctrl: AHB-Lite character FIFO, clear sequencer and paced tile-memory writer for text_screen_gen
// Optional irq output and CTRL[1] irq enable when VGA_CONS_IRQ_EN is defined.
module vga_text_console_ctrl
  import vga_cons_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter logic [6:0] BLANK_CHAR = BLANK_CHAR_DEF
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  input  logic        gen_busy,
  output logic        char_wen,
`ifdef VGA_CONS_IRQ_EN
  output logic [6:0]  char_data,
  output logic        irq
`else
  output logic [6:0]  char_data
`endif
);
  localparam int TOTAL = COLS * ROWS;
  localparam int CW = TOTAL > 1 ? $clog2(TOTAL) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  logic dp_wr, dp_rd;
  logic [1:0] dp_addr;
  logic data_wr, ctrl_wr, flush, push, pop, full, empty, irq_en;
  logic [6:0] head;
  logic [LW-1:0] level;
  logic [31:0] status;
  state_t state;
  logic clear_pending, clearing;
  logic [CW-1:0] cnt;
  logic unused_bits;
  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE, HWDATA[31:7]};
  assign data_wr = dp_wr && dp_addr == REG_DATA;
  assign ctrl_wr = dp_wr && dp_addr == REG_CTRL;
  assign flush = ctrl_wr && HWDATA[0];
  assign pop = state == S_IDLE && !clear_pending && !empty && !gen_busy;
  // A write into a full FIFO waits for a pop; same-cycle pop lets it through.
  assign push = data_wr && (!full || pop);
  assign HREADYOUT = !(data_wr && full && !pop);
  assign HRESP = 1'b0;
  assign HRDATA = dp_rd && dp_addr == REG_STATUS ? status : '0;
  always_comb begin
    status = '0;
    status[ST_LEVEL_LSB +: 8] = 8'(level);
    status[ST_IRQ_EN] = irq_en;
    status[ST_CLEARING] = clearing || clear_pending;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
  end
  vga_cons_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(7)) u_fifo (
    .HCLK(HCLK), .HRESETn(HRESETn), .push(push), .pop(pop), .flush(flush),
    .din(HWDATA[6:0]), .dout(head), .full(full), .empty(empty), .level(level)
  );
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      dp_wr <= 1'b0;
      dp_rd <= 1'b0;
      dp_addr <= '0;
    end else if (HREADY) begin
      dp_wr <= HSEL && HTRANS[1] && HWRITE;
      dp_rd <= HSEL && HTRANS[1] && !HWRITE;
      dp_addr <= HADDR[3:2];
    end
  // Clear blanks reuse ISSUE/SETTLE/WAIT; a clear request arriving mid-clear restarts from IDLE.
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state <= S_IDLE;
      char_wen <= 1'b0;
      char_data <= '0;
      clear_pending <= 1'b0;
      clearing <= 1'b0;
      cnt <= '0;
    end else begin
      char_wen <= 1'b0;
      case (state)
        S_IDLE:
          if (clear_pending) begin
            state <= S_CLEAR;
            clearing <= 1'b1;
            clear_pending <= 1'b0;
            cnt <= '0;
          end else if (pop) begin
            state <= S_ISSUE;
            char_wen <= 1'b1;
            char_data <= head;
          end
        S_CLEAR: begin
          state <= S_ISSUE;
          char_wen <= 1'b1;
          char_data <= BLANK_CHAR;
        end
        S_ISSUE: state <= S_SETTLE;
        S_SETTLE: state <= S_WAIT;
        S_WAIT:
          if (!gen_busy) begin
            if (clearing && !clear_pending && cnt != CW'(TOTAL - 1)) begin
              cnt <= cnt + 1'b1;
              state <= S_CLEAR;
            end else begin
              clearing <= 1'b0;
              state <= S_IDLE;
            end
          end
        default: state <= S_IDLE;
      endcase
      if (flush) clear_pending <= 1'b1;
    end
`ifdef VGA_CONS_IRQ_EN
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      irq_en <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= HWDATA[1];
      irq <= irq_en && level <= LW'(FIFO_DEPTH / 2) && !(clearing || clear_pending);
    end
`else
  assign irq_en = 1'b0;
`endif
endmodule

// File: tb/tb_vga_text_console_ctrl.sv
// tb_vga_text_console_ctrl: register-read table, directed corner cases and randomized character stream vs an expected-output queue
module tb_vga_text_console_ctrl;
  logic HCLK = 1'b0, HRESETn = 1'b0, HSEL = 1'b0, HWRITE = 1'b0, gen_busy = 1'b0;
  logic HREADY, HREADYOUT, HRESP, char_wen;
  logic [31:0] HADDR = '0, HWDATA = '0, HRDATA;
  logic [1:0] HTRANS = '0;
  logic [2:0] HSIZE = 3'd2;
  logic [6:0] char_data;
`ifdef VGA_CONS_IRQ_EN
  logic irq;
`endif
  assign HREADY = HREADYOUT;
  always #5 HCLK = ~HCLK;
  vga_text_console_ctrl #(.FIFO_DEPTH(16), .COLS(4), .ROWS(2), .BLANK_CHAR(7'h20)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .gen_busy(gen_busy),
`ifdef VGA_CONS_IRQ_EN
    .irq(irq),
`endif
    .char_wen(char_wen), .char_data(char_data)
  );
  int checks = 0, errors = 0;
  logic [6:0] exp_q[$];
  int n_emit = 0, cyc = 0, last_wen = -100, busy_cnt = 0, busy_len = 4;
  logic force_busy = 1'b0;
  typedef struct { logic [31:0] addr; logic [31:0] exp; } rd_vec_t;
  rd_vec_t tbl[4];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  // Generator model: busy for busy_len cycles after each write, or held by force_busy.
  always @(negedge HCLK) begin
    cyc++;
    if (char_wen) begin
      check("wen_while_busy", {31'b0, gen_busy}, 32'd0);
      check("wen_spacing", {31'b0, (cyc - last_wen) >= 3}, 32'd1);
      last_wen = cyc;
      n_emit++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wen: got char 0x%0h, expected no write", char_data);
      end else check("char_data", {25'b0, char_data}, {25'b0, exp_q.pop_front()});
      busy_cnt = busy_len;
    end else if (busy_cnt > 0) busy_cnt--;
    gen_busy = force_busy || busy_cnt > 0;
  end
  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d, output logic stalled);
    int n = 0;
    stalled = 1'b0;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    #1;
    while (!HREADYOUT && n < 1000) begin
      stalled = 1'b1;
      @(posedge HCLK); #2;
      n++;
    end
    check("write_stall_timeout", {31'b0, HREADYOUT}, 32'd1);
  endtask
  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    #1;
    d = HRDATA;
  endtask
  task automatic put(input logic [6:0] c);
    logic st;
    exp_q.push_back(c);
    ahb_write(32'h0, {25'b0, c}, st);
  endtask
  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(posedge HCLK);
      n++;
    end
    check("drain_remaining", exp_q.size(), 32'd0);
  endtask
  task automatic wait_emit(input int target);
    int n = 0;
    while (n_emit < target && n < 500) begin
      @(posedge HCLK);
      n++;
    end
    check("emit_timeout", {31'b0, n_emit >= target}, 32'd1);
  endtask
  initial begin
    logic [31:0] rd;
    logic st;
    int saved;
    tbl[0] = '{32'h4, 32'h1};
    tbl[1] = '{32'h0, 32'h0};
    tbl[2] = '{32'h8, 32'h0};
    tbl[3] = '{32'hC, 32'h0};
    #2;
    check("rst_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    check("rst_char_wen", {31'b0, char_wen}, 32'd0);
    check("rst_char_data", {25'b0, char_data}, 32'd0);
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_hresp", {31'b0, HRESP}, 32'd0);
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    foreach (tbl[i]) begin
      ahb_read(tbl[i].addr, rd);
      check($sformatf("read_%0h", tbl[i].addr), rd, tbl[i].exp);
    end
    busy_len = 4;
    put(7'h41);
    put(7'h42);
    wait_drain();
    ahb_read(32'h4, rd);
    check("status_after_two", rd, 32'h1);
    force_busy = 1'b1;
    @(negedge HCLK);
    for (int i = 0; i < 16; i++) put(7'(8'h50 + i));
    ahb_read(32'h4, rd);
    check("status_full", rd, 32'h1002);
    exp_q.push_back(7'h7e);
    fork
      ahb_write(32'h0, 32'h7e, st);
      begin
        repeat (4) @(posedge HCLK);
        #2;
        check("stall_hreadyout", {31'b0, HREADYOUT}, 32'd0);
        force_busy = 1'b0;
      end
    join
    check("write17_stalled", {31'b0, st}, 32'd1);
    wait_drain();
    ahb_read(32'h4, rd);
    check("status_after_stall", rd, 32'h1);
    for (int i = 0; i < 8; i++) exp_q.push_back(7'h20);
    ahb_write(32'h8, 32'h1, st);
    ahb_read(32'h4, rd);
    check("status_clearing", rd, 32'h5);
    put(7'h5a);
    wait_drain();
    ahb_read(32'h4, rd);
    check("status_after_clear", rd, 32'h1);
    repeat (30) @(posedge HCLK);
    for (int i = 0; i < 40; i++) begin
      if (i % 10 == 0) begin
        wait_drain();
        force_busy = 1'b1;
      end
      if (i % 10 == 5) force_busy = 1'b0;
      busy_len = $urandom_range(0, 6);
      put(7'($urandom_range(33, 126)));
      repeat ($urandom_range(0, 3)) @(posedge HCLK);
    end
    force_busy = 1'b0;
    busy_len = 4;
    wait_drain();
    ahb_read(32'h4, rd);
    check("status_after_random", rd, 32'h1);
`ifdef VGA_CONS_IRQ_EN
    ahb_write(32'h8, 32'h2, st);
    force_busy = 1'b1;
    @(negedge HCLK);
    for (int i = 0; i < 12; i++) put(7'(8'h61 + i));
    repeat (3) @(posedge HCLK);
    #2;
    check("irq_low_at_12", {31'b0, irq}, 32'd0);
    ahb_read(32'h4, rd);
    check("status_irq_12", rd, 32'h0C08);
    saved = n_emit;
    force_busy = 1'b0;
    wait_emit(saved + 4);
    repeat (2) @(posedge HCLK);
    #2;
    check("irq_high_at_8", {31'b0, irq}, 32'd1);
    wait_drain();
    ahb_read(32'h4, rd);
    check("status_irq_drained", rd, 32'h9);
`endif
    force_busy = 1'b1;
    @(negedge HCLK);
    for (int i = 0; i < 6; i++) put(7'(8'h30 + i));
    saved = n_emit;
    busy_len = 30;
    force_busy = 1'b0;
    wait_emit(saved + 1);
    repeat (5) @(posedge HCLK);
    #3 HRESETn = 1'b0;
    #1;
    check("midrst_char_wen", {31'b0, char_wen}, 32'd0);
    check("midrst_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    exp_q.delete();
    saved = n_emit;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    ahb_read(32'h4, rd);
    check("status_after_midrst", rd, 32'h1);
    repeat (60) @(posedge HCLK);
    check("no_wen_after_rst", n_emit, saved);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
